// File: rtl/bert_pkg.sv
// -----------------------------------------------------------------------------
// bert_pkg
// Shared types and constants for the GTX BERT receive-lane sequencer.
//   bert_state_t    : sequencer state encoding (also exported on the debug port)
//   LOCK_BLOCK_LEN  : block length used by the optional lock detector
//   LOCK_ERR_THRESH : errored cycles per block above which lock is lost
//   timer_width()   : width of a down-counter able to hold the largest load
// -----------------------------------------------------------------------------
package bert_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_DONE = 3'd2,
    SETTLE    = 3'd3,
    MEASURE   = 3'd4,
    FAULT     = 3'd5
  } bert_state_t;

  localparam int LOCK_BLOCK_LEN  = 256;
  localparam int LOCK_ERR_THRESH = 64;

  // One spare bit so that a load of exactly 2**n - 1 always fits.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/bert_sat_counter.sv
// -----------------------------------------------------------------------------
// bert_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high reset, count -> 0
//   clear : synchronous clear, count -> 0 (wins over en)
//   en    : increment by one this cycle (ignored once saturated)
//   count : current value
//   sat   : count is all-ones; stays high until clear/rst since count holds
// -----------------------------------------------------------------------------
module bert_sat_counter
  import bert_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (en && !(&count_reg)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;
  assign sat   = &count_reg;

endmodule

// File: rtl/bert_rx_controller.sv
// -----------------------------------------------------------------------------
// bert_rx_controller
// Sequencer for one GTX BERT receive lane: pulses gtrxreset, waits for a fresh
// rxresetdone, lets the PRBS checker settle, then integrates rxprbserr over a
// programmable window of clk cycles.
//
// Ports:
//   clk, rst        : RX user clock, synchronous active-high reset
//   start, abort    : one-cycle control pulses (abort wins over start)
//   window          : integration length, 0 = run until abort (sampled on start)
//   rx_reset_done   : GTX rxresetdone
//   prbs_err        : GTX rxprbserr (already registered)
//   gt_rx_reset     : drives gtrxreset
//   prbs_cnt_reset  : drives rxprbscntreset (final settle cycle)
//   busy, done      : not idle / one-cycle window-complete pulse
//   fault           : sticky rxresetdone timeout, cleared by start
//   state           : encoded state for debug
//   cycle_count     : integrated cycles (saturating)
//   err_count       : errored cycles (saturating), err_sat when all-ones
//   lock_lost, prbs_locked : only with BERT_LOCK_DETECT_EN defined
//
// Build option: define BERT_LOCK_DETECT_EN to add the 256-cycle block lock
// detector, which drops back to SETTLE when a block has more than 64 errors.
// -----------------------------------------------------------------------------
module bert_rx_controller
  import bert_pkg::*;
#(
  parameter int RESET_CYCLES   = 32,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int CYCLE_WIDTH    = 48,
  parameter int ERR_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CYCLE_WIDTH-1:0] window,
  input  logic                   rx_reset_done,
  input  logic                   prbs_err,
  output logic                   gt_rx_reset,
  output logic                   prbs_cnt_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [2:0]             state,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic                   err_sat
`ifdef BERT_LOCK_DETECT_EN
  ,
  output logic                   lock_lost,
  output logic                   prbs_locked
`endif
);

  localparam int TIMER_W = timer_width(RESET_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [TIMER_W-1:0] RESET_LOAD   = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_CYCLES - 1);

  bert_state_t            state_reg, state_next;
  logic [TIMER_W-1:0]     timer_reg, timer_next;
  logic                   seen_low_reg, seen_low_next;
  logic                   done_reg, done_next;
  logic                   fault_reg, fault_next;
  logic [CYCLE_WIDTH-1:0] window_reg, window_next;

  logic                   cnt_clear;
  logic                   cyc_en;
  logic                   err_en;
  logic                   cycle_sat;
  logic                   window_hit;

`ifdef BERT_LOCK_DETECT_EN
  localparam int BLK_W = $clog2(LOCK_BLOCK_LEN);
  logic [BLK_W-1:0] blk_cnt_reg, blk_cnt_next;
  logic [BLK_W:0]   blk_err_reg, blk_err_next, blk_err_sum;
  logic             lock_lost_reg, lock_lost_next;
  logic             blk_ok_reg, blk_ok_next;

  assign blk_err_sum = blk_err_reg + {{BLK_W{1'b0}}, prbs_err};
`endif

  // This cycle's increment is the one that brings cycle_count up to window.
  assign window_hit = (window_reg != '0) && !cycle_sat &&
                      (cycle_count == window_reg - CYCLE_WIDTH'(1));

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    seen_low_next = seen_low_reg;
    done_next     = 1'b0;
    fault_next    = fault_reg;
    window_next   = window_reg;
    cnt_clear     = 1'b0;
    cyc_en        = 1'b0;
    err_en        = 1'b0;
`ifdef BERT_LOCK_DETECT_EN
    blk_cnt_next   = blk_cnt_reg;
    blk_err_next   = blk_err_reg;
    lock_lost_next = lock_lost_reg;
    blk_ok_next    = blk_ok_reg;
`endif

    if (abort) begin
      // Abort beats start and window completion; the abort cycle is not counted.
      state_next = IDLE;
    end else if (start) begin
      state_next  = RESET;
      timer_next  = RESET_LOAD;
      fault_next  = 1'b0;
      window_next = window;
      cnt_clear   = 1'b1;
`ifdef BERT_LOCK_DETECT_EN
      lock_lost_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: ;

        RESET: begin
          if (timer_reg == '0) begin
            state_next    = WAIT_DONE;
            timer_next    = TIMEOUT_LOAD;
            seen_low_next = 1'b0;
          end else begin
            timer_next = timer_reg - TIMER_W'(1);
          end
        end

        WAIT_DONE: begin
          // A level that was already high when the reset released is stale:
          // only a rising of rxresetdone after a seen-low counts.
          seen_low_next = seen_low_reg | ~rx_reset_done;
          if (rx_reset_done && seen_low_reg) begin
            state_next = SETTLE;
            timer_next = SETTLE_LOAD;
          end else if (timer_reg == '0) begin
            state_next = FAULT;
            fault_next = 1'b1;
          end else begin
            timer_next = timer_reg - TIMER_W'(1);
          end
        end

        SETTLE: begin
          if (timer_reg == '0) begin
            state_next = MEASURE;
`ifdef BERT_LOCK_DETECT_EN
            blk_cnt_next = '0;
            blk_err_next = '0;
            blk_ok_next  = 1'b0;
`endif
          end else begin
            timer_next = timer_reg - TIMER_W'(1);
          end
        end

        MEASURE: begin
          if (!rx_reset_done) begin
            // Link dropped: wait for it again without re-issuing gtrxreset.
            // The drop itself is the required low observation.
            state_next    = WAIT_DONE;
            timer_next    = TIMEOUT_LOAD;
            seen_low_next = 1'b1;
          end else begin
            cyc_en = 1'b1;
            err_en = prbs_err;
`ifdef BERT_LOCK_DETECT_EN
            blk_cnt_next = blk_cnt_reg + BLK_W'(1);
            blk_err_next = blk_err_sum;
            if (blk_cnt_reg == BLK_W'(LOCK_BLOCK_LEN - 1)) begin
              blk_err_next = '0;
              if (blk_err_sum > (BLK_W + 1)'(LOCK_ERR_THRESH)) begin
                lock_lost_next = 1'b1;
                blk_ok_next    = 1'b0;
                state_next     = SETTLE;
                timer_next     = SETTLE_LOAD;
              end else begin
                blk_ok_next = 1'b1;
              end
            end
`endif
            // Window completion overrides a coincident lock loss.
            if (window_hit) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end

        FAULT: state_next = IDLE;

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      seen_low_reg <= 1'b0;
      done_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      window_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      seen_low_reg <= seen_low_next;
      done_reg     <= done_next;
      fault_reg    <= fault_next;
      window_reg   <= window_next;
    end
  end

`ifdef BERT_LOCK_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_reg   <= '0;
      blk_err_reg   <= '0;
      lock_lost_reg <= 1'b0;
      blk_ok_reg    <= 1'b0;
    end else begin
      blk_cnt_reg   <= blk_cnt_next;
      blk_err_reg   <= blk_err_next;
      lock_lost_reg <= lock_lost_next;
      blk_ok_reg    <= blk_ok_next;
    end
  end

  assign lock_lost   = lock_lost_reg;
  assign prbs_locked = (state_reg == MEASURE) && blk_ok_reg;
`endif

  bert_sat_counter #(.WIDTH(CYCLE_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cyc_en),
    .count (cycle_count),
    .sat   (cycle_sat)
  );

  bert_sat_counter #(.WIDTH(ERR_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (err_en),
    .count (err_count),
    .sat   (err_sat)
  );

  assign gt_rx_reset    = (state_reg == RESET);
  assign prbs_cnt_reset = (state_reg == SETTLE) && (timer_reg == '0);
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign fault          = fault_reg;
  assign state          = state_reg;

endmodule

// File: doc/bert_rx_controller.md
Name: bert_rx_controller

Overview:
Sequencer for one front-panel GTX BERT receive lane. Issues the GTX RX reset and waits for reset completion, then waits for the PRBS checker to settle. It then integrates PRBS error flags over a programmable window of RXUSRCLK cycles and reports error and cycle counts. Sits between the management register interface (already synchronized into the RX clock domain) and the transceiver's gtrxreset, rxresetdone, rxprbscntreset and rxprbserr signals.

Parameters:
RESET_CYCLES, 32, gtrxreset pulse width in clk cycles
TIMEOUT_CYCLES, 65536, max wait for rxresetdone before fault
SETTLE_CYCLES, 1024, cycles after resetdone before counting starts
CYCLE_WIDTH, 48, width of integration window and cycle counter
ERR_WIDTH, 32, width of saturating error counter

Ports:
clk  in  1  RX user clock of the lane
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin reset and measurement
abort  in  1  one-cycle pulse: stop measurement, go IDLE
window  in  CYCLE_WIDTH  integration length in clk cycles; 0 = run until abort
rx_reset_done  in  1  GTX rxresetdone
prbs_err  in  1  GTX rxprbserr, registered
gt_rx_reset  out  1  drives gtrxreset
prbs_cnt_reset  out  1  drives rxprbscntreset
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when window completes
fault  out  1  sticky reset timeout, cleared by start
state  out  3  encoded state, for debug and ILA
cycle_count  out  CYCLE_WIDTH  cycles integrated
err_count  out  ERR_WIDTH  cycles with prbs_err=1, saturating
err_sat  out  1  err_count saturated

Behaviour:
- Single clock domain. Synchronous active-high reset. All outputs reset to 0 and state resets to IDLE.
- IDLE(0):
  - start → RESET.
  - On entry to RESET: clear cycle_count, err_count, err_sat and fault, and load the timer.
- RESET(1):
  - gt_rx_reset=1 for exactly RESET_CYCLES cycles, then → WAIT_DONE.
- WAIT_DONE(2):
  - rx_reset_done=1 → SETTLE.
  - TIMEOUT_CYCLES elapsed with rx_reset_done=0 → FAULT.
  - rx_reset_done must be seen low at least once after gt_rx_reset deasserts. A stale high level is ignored.
- SETTLE(3):
  - Wait SETTLE_CYCLES.
  - prbs_cnt_reset=1 on the final settle cycle.
  - Then → MEASURE.
- MEASURE(4):
  - Every cycle, cycle_count += 1.
  - If prbs_err, err_count += 1, saturating at all-ones. err_sat sets when err_count reaches all-ones and stays set.
  - When window != 0 and cycle_count reaches window: the last increment occurs, done pulses the following cycle, state → IDLE. Counts hold until the next start.
  - window is sampled on the start cycle. Later changes to window are ignored.
- FAULT(5):
  - fault=1, then → IDLE next cycle. fault stays sticky until start.
- abort in any non-IDLE state:
  - → IDLE next cycle, gt_rx_reset deasserts, counts hold, no done pulse.
  - abort takes priority over the window-complete event in the same cycle.
- start while busy restarts from RESET, equivalent to abort followed by start. start together with abort in the same cycle: abort wins.
- rst mid-operation returns to IDLE with all outputs cleared.
- rx_reset_done dropping during MEASURE increments neither counter. The block → WAIT_DONE without re-issuing the reset, and keeps the timeout.
- cycle_count never wraps. If window=0 and the counter reaches all-ones, it holds there.

Optional Feature:
- Macro: BERT_LOCK_DETECT_EN.
- When defined:
  - MEASURE tracks errors within consecutive 256-cycle blocks.
  - A block with more than 64 errored cycles sets output lock_lost (sticky until start) and sends the FSM → SETTLE. Counters are preserved; prbs_cnt_reset pulses again.
  - Port prbs_locked = in MEASURE and the last block ≤ 64 errors.
- When undefined:
  - lock_lost and prbs_locked are absent.
  - MEASURE never leaves except by window, abort or loss of rx_reset_done.

Decomposition:
- Package bert_pkg holds:
  - enum bert_state_t (IDLE, RESET, WAIT_DONE, SETTLE, MEASURE, FAULT) as logic[2:0].
  - Lock-detect constants LOCK_BLOCK_LEN=256 and LOCK_ERR_THRESH=64.
- One natural sub-module, bert_sat_counter: parameterized-width counter with clear, enable and saturate flag. It is used for both err_count and cycle_count.

Test Plan:
1. start, window=1000, rx_reset_done rises 10 cycles after reset release, prbs_err=0 → gt_rx_reset high 32 cycles, prbs_cnt_reset single pulse, done pulse, cycle_count=1000, err_count=0.
2. Same as 1, with prbs_err asserted on exactly 7 cycles within the window → err_count=7; errors injected during SETTLE are not counted.
3. rx_reset_done held 0 → fault=1 after 65536 WAIT_DONE cycles, state returns to IDLE, busy=0; the next start clears fault.
4. ERR_WIDTH=4, prbs_err=1 continuously, window=100 → err_count=15, err_sat=1, cycle_count=100.
5. abort at cycle 500 of window=1000 → IDLE next cycle, no done, cycle_count≈500 held; rst mid-MEASURE → all outputs 0.
6. With BERT_LOCK_DETECT_EN: 100 errors in one 256-cycle block → lock_lost=1, state → SETTLE, prbs_cnt_reset pulses, counters retained.
